// File: rtl/ldr_pkg.sv
// Shared types and constants for the Levinson-Durbin CSR block:
// FSM states, word-address map, register bit positions and the unmapped-read value.
package ldr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TMO  = 2'd3
  } ldr_state_e;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_CYCLES = 8'h02;
  localparam logic [7:0] R_BASE      = 8'h20;
  localparam logic [7:0] A_BASE      = 8'h40;

  localparam int CTRL_SOFT_RESET = 0;
  localparam int CTRL_START      = 1;
  localparam int CTRL_IRQ_EN     = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_WR_ERR  = 3;

  localparam logic [15:0] BAD_READ = 16'h0BAD;

endpackage

// File: rtl/ldr_csr_fsm.sv
// Run sequencer for the Levinson-Durbin core: IDLE/RUN/DONE/TMO FSM, RUN-cycle counter,
// timeout compare and the one-cycle core_start / core_rst pulses.
module ldr_csr_fsm
  import ldr_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              start_req,
  input  logic              core_done,
  output ldr_state_e        state,
  output logic [DATA_W-1:0] cycles,
  output logic              core_start,
  output logic              core_rst,
  output logic              ev_start,
  output logic              ev_done,
  output logic              ev_timeout,
  output logic              start_err
);

  ldr_state_e        state_nxt;
  logic [DATA_W-1:0] cycles_nxt;
  logic [DATA_W-1:0] cycles_inc;
  logic              start_nxt;
  logic              rst_nxt;

  // Holding at TIMEOUT keeps a done-on-the-timeout-cycle from overshooting the limit.
  assign cycles_inc = (cycles == DATA_W'(TIMEOUT) || &cycles) ? cycles : cycles + DATA_W'(1);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt  = state;
    cycles_nxt = cycles;
    start_nxt  = 1'b0;
    rst_nxt    = 1'b0;
    ev_start   = 1'b0;
    ev_done    = 1'b0;
    ev_timeout = 1'b0;
    start_err  = 1'b0;
    if (soft_reset) begin
      state_nxt  = ST_IDLE;
      cycles_nxt = '0;
      rst_nxt    = 1'b1;
    end else if (state == ST_RUN) begin
      start_err = start_req;
      if (core_done) begin
        state_nxt  = ST_DONE;
        cycles_nxt = cycles_inc;
        ev_done    = 1'b1;
      end else if (cycles == DATA_W'(TIMEOUT)) begin
        state_nxt  = ST_TMO;
        rst_nxt    = 1'b1;
        ev_timeout = 1'b1;
      end else begin
        cycles_nxt = cycles_inc;
      end
    end else if (start_req) begin
      state_nxt  = ST_RUN;
      cycles_nxt = '0;
      start_nxt  = 1'b1;
      ev_start   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state      <= ST_IDLE;
      cycles     <= '0;
      core_start <= 1'b0;
      core_rst   <= 1'b1;
    end else begin
      state      <= state_nxt;
      cycles     <= cycles_nxt;
      core_start <= start_nxt;
      core_rst   <= rst_nxt;
    end
  end

endmodule

// File: rtl/ldr_avalon_csr.sv
// Avalon-MM CSR slave for a Levinson-Durbin core: R inputs, A shadows, control/status, LEDs.
// Optional interrupt output enabled by defining LDR_CSR_IRQ_EN.
module ldr_avalon_csr
  import ldr_pkg::*;
#(
  parameter int ORDER   = 10,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [DATA_W-1:0]         avs_writedata,
  output logic [DATA_W-1:0]         avs_readdata,
  output logic                      core_rst,
  output logic                      core_start,
  output logic [(ORDER+1)*DATA_W-1:0] core_r,
  input  logic [(ORDER+1)*DATA_W-1:0] core_a,
  input  logic                      core_done,
  output logic                      irq,
  output logic [7:0]                led
);

  logic [DATA_W-1:0] r_q [ORDER+1];
  logic [DATA_W-1:0] a_q [ORDER+1];
  logic              st_done_q, st_tmo_q, wr_err_q, irq_en_q;
  logic              ctrl_wr, status_wr, soft_reset, start_req, busy;
  logic              ev_start, ev_done, ev_timeout, start_err;
  logic              r_wr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] cycles;
  ldr_state_e        state;

  assign ctrl_wr    = avs_write && (avs_address == ADDR_W'(ADDR_CTRL));
  assign status_wr  = avs_write && (avs_address == ADDR_W'(ADDR_STATUS));
  assign soft_reset = ctrl_wr && avs_writedata[CTRL_SOFT_RESET];
  assign start_req  = ctrl_wr && avs_writedata[CTRL_START] && !soft_reset;
  assign busy       = (state == ST_RUN);

  always_comb begin
    r_wr = 1'b0;
    for (int i = 0; i <= ORDER; i++)
      if (avs_address == ADDR_W'(int'(R_BASE) + i)) r_wr = avs_write;
  end

  ldr_csr_fsm #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .start_req  (start_req),
    .core_done  (core_done),
    .state      (state),
    .cycles     (cycles),
    .core_start (core_start),
    .core_rst   (core_rst),
    .ev_start   (ev_start),
    .ev_done    (ev_done),
    .ev_timeout (ev_timeout),
    .start_err  (start_err)
  );

  always_ff @(posedge clk) begin
    // NOTE: R and A are a handful of flops that must read back 0 after reset, so they are reset.
    if (reset) begin
      st_done_q <= 1'b0;
      st_tmo_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      for (int i = 0; i <= ORDER; i++) begin
        r_q[i] <= '0;
        a_q[i] <= '0;
      end
    end else begin
      if (status_wr) begin
        if (avs_writedata[STAT_DONE])    st_done_q <= 1'b0;
        if (avs_writedata[STAT_TIMEOUT]) st_tmo_q  <= 1'b0;
        if (avs_writedata[STAT_WR_ERR])  wr_err_q  <= 1'b0;
      end
      if (ev_start) begin
        st_done_q <= 1'b0;
        st_tmo_q  <= 1'b0;
      end
      if (ev_done) begin
        st_done_q <= 1'b1;
        for (int i = 0; i <= ORDER; i++) a_q[i] <= core_a[i*DATA_W +: DATA_W];
      end
      if (ev_timeout) st_tmo_q <= 1'b1;
      // Hardware events take priority over a simultaneous W1C.
      if (start_err || (r_wr && busy)) wr_err_q <= 1'b1;
      for (int i = 0; i <= ORDER; i++)
        if (avs_write && !busy && avs_address == ADDR_W'(int'(R_BASE) + i))
          r_q[i] <= avs_writedata;
      if (soft_reset) begin
        st_done_q <= 1'b0;
        st_tmo_q  <= 1'b0;
        wr_err_q  <= 1'b0;
        for (int i = 0; i <= ORDER; i++) a_q[i] <= '0;
      end
    end
  end

`ifdef LDR_CSR_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset)        irq_en_q <= 1'b0;
    else if (ctrl_wr) irq_en_q <= avs_writedata[CTRL_IRQ_EN];
  end
  assign irq = irq_en_q && (st_done_q || st_tmo_q);
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata = DATA_W'(BAD_READ);
    if (avs_address == ADDR_W'(ADDR_CTRL)) begin
      rdata              = '0;
      rdata[CTRL_IRQ_EN] = irq_en_q;
    end else if (avs_address == ADDR_W'(ADDR_STATUS)) begin
      rdata               = '0;
      rdata[STAT_BUSY]    = busy;
      rdata[STAT_DONE]    = st_done_q;
      rdata[STAT_TIMEOUT] = st_tmo_q;
      rdata[STAT_WR_ERR]  = wr_err_q;
    end else if (avs_address == ADDR_W'(ADDR_CYCLES)) begin
      rdata = cycles;
    end
    for (int i = 0; i <= ORDER; i++) begin
      if (avs_address == ADDR_W'(int'(R_BASE) + i)) rdata = r_q[i];
      if (avs_address == ADDR_W'(int'(A_BASE) + i)) rdata = a_q[i];
    end
  end

  // Registered before any same-cycle write lands, so a read/write collision returns the old value.
  always_ff @(posedge clk) begin
    if (reset) avs_readdata <= '0;
    else       avs_readdata <= avs_read ? rdata : '0;
  end

  for (genvar i = 0; i <= ORDER; i++) begin : g_core_r
    assign core_r[i*DATA_W +: DATA_W] = r_q[i];
  end

  assign led = {4'hF, ~wr_err_q, ~(state == ST_TMO), ~(state == ST_DONE), ~busy};

endmodule
